// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet transmitter.
//
// Contents:
//   uart_state_e           - character-level FSM state encoding
//   DEFAULT_REG_SIZE       - default bytes per packet
//   DEFAULT_UART_BIT_WIDTH - default data bits per character
//   DEFAULT_CLKS_PER_BIT   - default clk cycles per UART bit
//
// Optional feature macro: UART_PARITY_EN (adds the PARITY state).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DEFAULT_REG_SIZE       = 28;
    localparam int DEFAULT_UART_BIT_WIDTH = 8;
    localparam int DEFAULT_CLKS_PER_BIT   = 868;

endpackage

// File: rtl/uart_byte_tx.sv
// Single-character UART transmitter.
//
// Sends start bit (0), data bits LSB first, optional even-parity bit,
// then stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
//
// Ports:
//   clk         - system clock (rising edge)
//   n_rst       - asynchronous active-low reset
//   valid_i     - a character is offered on data_i
//   data_i      - character to send
//   ready_o     - character accepted this cycle if valid_i is high
//                 (in IDLE, or in the final stop-bit cycle so characters
//                 chain without an idle gap)
//   char_done_o - final cycle of the stop bit
//   tx_o        - serial line, registered, idle high
//
// Optional feature macro: UART_PARITY_EN (even parity after data bits).
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int UART_BIT_WIDTH = DEFAULT_UART_BIT_WIDTH,
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      valid_i,
    input  logic [UART_BIT_WIDTH-1:0] data_i,
    output logic                      ready_o,
    output logic                      char_done_o,
    output logic                      tx_o
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (UART_BIT_WIDTH > 1) ? $clog2(UART_BIT_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_BIT_WIDTH - 1);

    uart_state_e               state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [BIT_W-1:0]          bit_inc;
    logic [UART_BIT_WIDTH-1:0] data_q, data_d;
    logic                      tx_q, tx_d;
    logic                      baud_last;

    assign baud_last   = (baud_q == BAUD_LAST);
    assign bit_inc     = bit_q + 1'b1;
    assign ready_o     = (state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last);
    assign char_done_o = (state_q == ST_STOP) && baud_last;
    assign tx_o        = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;

        // Baud counter runs in every active state and wraps at each bit
        // boundary, so a bit transition always coincides with baud_last.
        if (state_q != ST_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + 1'b1;
        end

        // tx_d is the value the line takes in the *next* bit, so every
        // transition loads the first level of the state being entered.
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (valid_i) begin
                    state_d = ST_START;
                    data_d  = data_i;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_inc;
                        tx_d  = data_q[bit_inc];
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    if (valid_i) begin
                        state_d = ST_START;
                        data_d  = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_packet_tx.sv
// UART packet transmitter: sends REG_SIZE characters back-to-back from a
// snapshot of iDataReg taken when iStart is accepted.
//
// Ports:
//   clk      - system clock (rising edge)
//   n_rst    - asynchronous active-low reset; aborts any packet in flight
//   iStart   - one-cycle request to send the current packet
//   iDataReg - packet bytes, index 0 sent first
//   oTx      - serial line, idle high
//   oBusy    - packet in flight (cycle after acceptance to last stop cycle)
//   oDone    - one-cycle pulse in the first idle cycle after a packet
//   oDropCnt - saturating count of iStart requests ignored while busy
//
// Optional feature macro: UART_PARITY_EN (even parity bit per character).
module uart_packet_tx
    import uart_pkg::*;
#(
    parameter int REG_SIZE       = DEFAULT_REG_SIZE,
    parameter int UART_BIT_WIDTH = DEFAULT_UART_BIT_WIDTH,
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      iStart,
    input  logic [UART_BIT_WIDTH-1:0] iDataReg [REG_SIZE],
    output logic                      oTx,
    output logic                      oBusy,
    output logic                      oDone,
    output logic [15:0]               oDropCnt
);

    localparam int IDX_W = $clog2(REG_SIZE + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REG_SIZE - 1);

    logic [UART_BIT_WIDTH-1:0] snap_q [REG_SIZE];
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          idx_next;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [15:0]               drop_q, drop_d;

    logic                      accept;
    logic                      last_byte;
    logic                      byte_valid;
    logic [UART_BIT_WIDTH-1:0] byte_data;
    logic [UART_BIT_WIDTH-1:0] next_byte;
    logic                      byte_ready;
    logic                      char_done;

    assign accept    = iStart && !busy_q;
    assign last_byte = (idx_q == IDX_LAST);
    assign idx_next  = idx_q + 1'b1;

    // Byte 0 is taken straight from iDataReg so the start bit goes out in
    // the cycle right after acceptance; later bytes come from the snapshot.
    // While busy the next byte is always offered; the character
    // transmitter only consumes it at the end of the current stop bit.
    assign byte_valid = accept || (busy_q && !last_byte);
    assign byte_data  = accept ? iDataReg[0] : next_byte;

    always_comb begin
        next_byte = '0;
        for (int i = 0; i < REG_SIZE; i++) begin
            if (idx_next == IDX_W'(i)) begin
                next_byte = snap_q[i];
            end
        end
    end

    always_comb begin
        idx_d  = idx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        drop_d = drop_q;

        if (accept) begin
            idx_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (byte_ready && !last_byte) begin
                idx_d = idx_next;
            end
            if (char_done && last_byte) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end

        if (iStart && busy_q && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < REG_SIZE; i++) begin
                snap_q[i] <= '0;
            end
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            drop_q <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < REG_SIZE; i++) begin
                    snap_q[i] <= iDataReg[i];
                end
            end
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    uart_byte_tx #(
        .UART_BIT_WIDTH (UART_BIT_WIDTH),
        .CLKS_PER_BIT   (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk         (clk),
        .n_rst       (n_rst),
        .valid_i     (byte_valid),
        .data_i      (byte_data),
        .ready_o     (byte_ready),
        .char_done_o (char_done),
        .tx_o        (oTx)
    );

    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oDropCnt = drop_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
module tb_uart_packet_tx;

    localparam int REG = 2;
    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int NB  = W + 3;
`else
    localparam int NB  = W + 2;
`endif
    localparam int PKT_CYCLES = REG * NB * CPB;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         iStart = 1'b0;
    logic [W-1:0] data_reg [REG];
    logic         oTx, oBusy, oDone;
    logic [15:0]  oDropCnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int exp_drop = 0;
    int exp_done = 0;
    int done_seen = 0;
    int exp_q [$];          // expected frames; bit 16 marks last byte of packet
    logic [W-1:0] pkt [REG];

    uart_packet_tx #(
        .REG_SIZE       (REG),
        .UART_BIT_WIDTH (W),
        .CLKS_PER_BIT   (CPB)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .iStart   (iStart),
        .iDataReg (data_reg),
        .oTx      (oTx),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oDropCnt (oDropCnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (n_rst && oDone) done_seen <= done_seen + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Line-level frame: bit0 = start(0), data LSB first, [even parity], stop(1).
    function automatic int frame_of(input logic [W-1:0] d);
        int ones = 0;
        int f;
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        f = int'(d) << 1;
`ifdef UART_PARITY_EN
        f = f | ((ones % 2) << (W + 1));
`endif
        f = f | (1 << (NB - 1));
        return f;
    endfunction

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic start_packet(input bit scribble);
        for (int i = 0; i < REG; i++) begin
            data_reg[i] = pkt[i];
            exp_q.push_back(frame_of(pkt[i]) | ((i == REG - 1) ? (1 << 16) : 0));
        end
        $display("txn start bytes0=%02h bytes1=%02h scribble=%0d", pkt[0], pkt[1], scribble);
        iStart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iStart = 1'b0;
        t0 = cyc;
        chk("start_edge", {oTx, oBusy}, 2'b01);
        if (scribble) begin
            for (int i = 0; i < REG; i++) data_reg[i] = '1;
        end
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int k = 0; k < 4000 && !got; k++) begin
            if (oDone === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", got, 1);
        chk("done_latency", cyc - t0 + 1, PKT_CYCLES + 1);
        exp_done++;
    endtask

    // Monitor: receives each character off oTx and checks it against the queue.
    initial begin : monitor
        logic [NB-1:0] rx;
        logic [NB-1:0] ef;
        bit glitch, aborted, busy_ok, expect_next;
        int e;
        expect_next = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                expect_next = 1'b0;
            end else begin
                if (expect_next && oTx !== 1'b0) begin
                    chk("byte_gap", oTx, 0);
                    expect_next = 1'b0;
                end
                if (oTx === 1'b0) begin
                    expect_next = 1'b0;
                    rx = '0; glitch = 1'b0; aborted = 1'b0; busy_ok = 1'b1;
                    for (int b = 0; b < NB && !aborted; b++) begin
                        for (int c = 0; c < CPB && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (!n_rst) aborted = 1'b1;
                            else begin
                                if (c == 0) rx[b] = oTx;
                                else if (oTx !== rx[b]) glitch = 1'b1;
                                if (!oBusy) busy_ok = 1'b0;
                            end
                        end
                    end
                    if (aborted) begin
                        $display("txn char aborted by reset");
                        while (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            if (e[16]) break;
                        end
                    end else if (exp_q.size() == 0) begin
                        chk("unexpected_char", rx, 0);
                    end else begin
                        e = exp_q.pop_front();
                        ef = e[NB-1:0];
                        $display("txn char rx=%03h exp=%03h", rx, ef);
                        chk("char_frame", rx, ef);
                        chk("bit_stable", glitch, 0);
                        chk("busy_in_char", busy_ok, 1);
                        if (e[16]) begin
                            @(negedge clk);
                            chk("done_after_stop", {oDone, oBusy}, 2'b10);
                        end else begin
                            expect_next = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        int done_before;
        for (int i = 0; i < REG; i++) data_reg[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", oTx, 1);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_drop", oDropCnt, 0);
        #2 n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // Directed reference packet
        pkt[0] = 8'hA5; pkt[1] = 8'h3C;
        start_packet(1'b0);
        wait_done();

        // Parity corner bytes (odd and even number of ones)
        @(negedge clk);
        pkt[0] = 8'h07; pkt[1] = 8'h03;
        start_packet(1'b0);
        wait_done();

        // Drops while busy, plus input change after acceptance
        repeat (2) @(negedge clk);
        pkt[0] = 8'h5A; pkt[1] = 8'hC3;
        start_packet(1'b1);
        for (int p = 0; p < 3; p++) begin
            repeat (5) @(negedge clk);
            iStart = 1'b1;
            @(negedge clk);
            iStart = 1'b0;
            exp_drop++;
        end
        wait_done();
        chk("drop_count", oDropCnt, exp_drop);

        // iStart in the oDone cycle is accepted with no gap
        @(negedge clk);
        pkt[0] = 8'h81; pkt[1] = 8'h7E;
        start_packet(1'b0);
        wait_done();
        pkt[0] = 8'h00; pkt[1] = 8'hFF;
        start_packet(1'b0);
        chk("drop_unchanged", oDropCnt, exp_drop);
        wait_done();

        // Reset asserted during byte 1
        repeat (3) @(negedge clk);
        pkt[0] = 8'h96; pkt[1] = 8'h69;
        start_packet(1'b0);
        repeat (NB * CPB + 6) @(negedge clk);
        done_before = done_seen;
        #2 n_rst = 1'b0;
        #1;
        chk("abort_tx", oTx, 1);
        chk("abort_busy", oBusy, 0);
        chk("abort_drop", oDropCnt, 0);
        exp_drop = 0;
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_no_done", done_seen, done_before);
        chk("abort_idle_tx", oTx, 1);
        pkt[0] = 8'h96; pkt[1] = 8'h69;
        start_packet(1'b0);
        wait_done();

        // Randomized packets
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            for (int i = 0; i < REG; i++) pkt[i] = W'($urandom);
            start_packet(1'($urandom_range(0, 1)));
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_seen, exp_done);
        chk("drop_final", oDropCnt, exp_drop);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
